// File: rtl/board_scanner.sv
// Samples the centre pixel of each 8x8 playfield cell from the framebuffer and publishes a COLS x ROWS occupancy bitmap.
// Optional macro BOARD_STABLE_EN: publish only when two consecutive scans agree.
module board_scanner #(
    parameter int          X0       = 16,
    parameter int          Y0       = 0,
    parameter int          COLS     = 10,
    parameter int          ROWS     = 18,
    parameter logic [1:0]  BG_SHADE = 2'd0,
    parameter int          RD_LAT   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [14:0]            fb_addr,
    input  logic [1:0]             fb_q,
    output logic [ROWS*COLS-1:0]   board,
    output logic                   board_valid,
    output logic                   busy
);
    localparam int NCELL = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [14:0] A_FIRST  = 15'((Y0 + 4) * 160 + X0 + 4);
    localparam logic [14:0] COL_STEP = 15'd8;
    localparam logic [14:0] ROW_STEP = 15'(1280 - (COLS - 1) * 8);
    localparam logic [1:0]  WAIT_INIT = 2'(RD_LAT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [1:0]       r_wcnt;
    logic [14:0]      r_addr;
    logic             r_pending;
    logic             r_busy;
    logic             r_valid;
    logic [NCELL-1:0] r_shadow;
    logic [NCELL-1:0] r_board;
    logic             w_hit;
    logic             w_last;
    logic             w_col_end;
    logic             w_publish;

`ifdef BOARD_STABLE_EN
    logic [NCELL-1:0] r_prev;
    logic             r_prev_vld;
    assign w_publish = r_prev_vld && (r_prev == r_shadow);
`else
    assign w_publish = 1'b1;
`endif

    assign w_hit     = (fb_q != BG_SHADE);
    assign w_col_end = (r_col == CW'(COLS - 1));
    assign w_last    = w_col_end && (r_row == RW'(ROWS - 1));

    assign fb_addr     = r_addr;
    assign board       = r_board;
    assign board_valid = r_valid;
    assign busy        = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_wcnt    <= '0;
            r_addr    <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_shadow  <= '0;
            r_board   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (start && r_state != S_IDLE && r_state != S_DONE)
                r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_busy  <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_addr  <= A_FIRST;
                    end
                end
                S_ISSUE: begin
                    r_wcnt  <= WAIT_INIT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wcnt == 2'd0) r_state <= S_CAP;
                    else                r_wcnt  <= r_wcnt - 2'd1;
                end
                S_CAP: begin
                    // Cells arrive in bit order, so a right shift lands cell 0 at bit 0 after the last one.
                    r_shadow <= {w_hit, r_shadow[NCELL-1:1]};
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_ISSUE;
                        if (w_col_end) begin
                            r_col  <= '0;
                            r_row  <= r_row + RW'(1);
                            r_addr <= r_addr + ROW_STEP;
                        end else begin
                            r_col  <= r_col + CW'(1);
                            r_addr <= r_addr + COL_STEP;
                        end
                    end
                end
                S_DONE: begin
                    if (w_publish) begin
                        r_board <= r_shadow;
                        r_valid <= 1'b1;
                    end
                    if (r_pending || start) begin
                        r_pending <= 1'b0;
                        r_state   <= S_ISSUE;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_addr    <= A_FIRST;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BOARD_STABLE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_prev     <= r_shadow;
            r_prev_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: framebuffer model with a 2-cycle read pipe, hand-computed expectations.
module tb_board_scanner;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [14:0]  fb_addr;
    logic [1:0]   fb_q;
    logic [179:0] board;
    logic         board_valid;
    logic         busy;

    logic [1:0]   fb [0:23039];
    logic [1:0]   p1, p2;
    int           cyc = 0;
    int           checks = 0;
    int           fails = 0;
    bit           trace_on = 1'b0;
    logic [14:0]  last_addr = '0;
    logic [14:0]  trace [$];

    board_scanner dut (
        .clk(clk), .reset(reset), .start(start), .fb_addr(fb_addr), .fb_q(fb_q),
        .board(board), .board_valid(board_valid), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        p1 <= fb[fb_addr];
        p2 <= p1;
    end
    assign fb_q = p2;

    always @(negedge clk) begin
        if (trace_on && busy && fb_addr != last_addr) begin
            trace.push_back(fb_addr);
            last_addr = fb_addr;
        end
    end

    task automatic chk(input string tag, input logic [179:0] obs, input logic [179:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_fb();
        for (int i = 0; i < 23040; i++) fb[i] = 2'd0;
    endtask

    task automatic do_scan(output bit got, output logic [179:0] b, output int lat, output bit tmo);
        int t0;
        got = 1'b0; b = '0; lat = 0; tmo = 1'b1;
        @(posedge clk); #1 start = 1'b1; t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (board_valid) begin got = 1'b1; b = board; lat = cyc - t0; end
            if (!busy) begin tmo = 1'b0; break; end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        bit got, tmo;
        logic [179:0] b;
        int lat, t0, np, pa, pb, nbv;

        clear_fb();
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 180'(fb_addr), 180'd0);
        chk("rst_board", board, 180'd0);
        chk("rst_valid", 180'(board_valid), 180'd0);
        chk("rst_busy", 180'(busy), 180'd0);
        reset = 1'b0;

        // All-background frame: latency, empty board, address walk
        trace_on = 1'b1;
        do_scan(got, b, lat, tmo);
        trace_on = 1'b0;
        chk("bg_timeout", 180'(tmo), 180'd0);
        chk("bg_got", 180'(got), 180'd1);
        chk("bg_latency", 180'(lat), 180'd722);
        chk("bg_board", b, 180'd0);
        @(negedge clk);
        chk("bg_valid_1cyc", 180'(board_valid), 180'd0);
        chk("bg_busy_after", 180'(busy), 180'd0);
        chk("trace_len", 180'(trace.size()), 180'd180);
        if (trace.size() == 180) begin
            chk("trace_first", 180'(trace[0]), 180'd660);
            chk("trace_second", 180'(trace[1]), 180'd668);
            chk("trace_row1", 180'(trace[10]), 180'd1940);
            // last cell centre is pixel (92,140)
            chk("trace_last", 180'(trace[179]), 180'd22492);
        end

        fb[4 * 160 + 20] = 2'd3;
        do_scan(got, b, lat, tmo);
        chk("px0_got", 180'(got), 180'd1);
        chk("px0_board", b, 180'd1);
        fb[4 * 160 + 20] = 2'd0;

        fb[140 * 160 + 92] = 2'd1;
        do_scan(got, b, lat, tmo);
        chk("px179_got", 180'(got), 180'd1);
        chk("px179_board", b, 180'd1 << 179);

        // Three starts during one scan collapse into one extra scan
        @(posedge clk); #1 start = 1'b1; t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        np = 0; pa = 0; pb = 0;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            if (board_valid) begin
                np++;
                if (np == 1) pa = cyc; else if (np == 2) pb = cyc;
            end
            start = (i == 100 || i == 200 || i == 300);
        end
        start = 1'b0;
        chk("multi_pulses", 180'(np), 180'd2);
        chk("multi_first_lat", 180'(pa - t0), 180'd722);
        chk("multi_interval", 180'(pb - pa), 180'd721);
        chk("multi_board", board, 180'd1 << 179);
        chk("multi_busy_end", 180'(busy), 180'd0);

        // Reset partway through a scan
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (298) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_board", board, 180'd0);
        chk("mid_rst_busy", 180'(busy), 180'd0);
        chk("mid_rst_addr", 180'(fb_addr), 180'd0);
        @(posedge clk); #1 reset = 1'b0;
        nbv = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (board_valid) nbv++;
        end
        chk("mid_rst_no_valid", 180'(nbv), 180'd0);
        chk("mid_rst_idle", 180'(busy), 180'd0);
        fb[140 * 160 + 92] = 2'd0;
        fb[4 * 160 + 20] = 2'd2;
        do_scan(got, b, lat, tmo);
        chk("post_rst_got", 180'(got), 180'd1);
        chk("post_rst_lat", 180'(lat), 180'd722);
        chk("post_rst_board", b, 180'd1);
        fb[4 * 160 + 20] = 2'd0;

        // Cell 5 (pixel (60,4)) toggles for three frames, then holds
        pulse_reset();
        for (int f = 0; f < 4; f++) begin
            fb[4 * 160 + 60] = (f == 1) ? 2'd0 : 2'd1;
            do_scan(got, b, lat, tmo);
            chk("alt_timeout", 180'(tmo), 180'd0);
`ifdef BOARD_STABLE_EN
            chk("alt_got", 180'(got), (f == 3) ? 180'd1 : 180'd0);
            if (f == 3) chk("alt_board", b, 180'd1 << 5);
`else
            chk("alt_got", 180'(got), 180'd1);
            chk("alt_board", b, (f == 1) ? 180'd0 : (180'd1 << 5));
`endif
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
